// File: rtl/line_mem_pkg.sv
// Shared definitions for the line memory block.
// Holds the controller state encoding, the operation type and the
// default parameter values used by line_memory and line_ram.
package line_mem_pkg;

  localparam int unsigned LM_LINE_BYTES  = 16;
  localparam int unsigned LM_DEPTH_LINES = 64;
  localparam int unsigned LM_ADDR_W      = 28;
  localparam int unsigned LM_LATENCY     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Bits needed to hold latency-1, never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Line storage array: DEPTH_LINES lines of LINE_BYTES bytes.
// Ports:
//   clock   - write clock
//   wr_en   - write strobe, sampled on the rising edge
//   wr_idx  - line index written
//   wr_data - write line, byte k at [8k+7:8k]
//   wr_mask - per-byte write enable
//   rd_idx  - line index read
//   rd_data - combinational read of line rd_idx
// The array has no reset; contents survive a controller reset.
module line_ram
  import line_mem_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = LM_LINE_BYTES,
  parameter int unsigned DEPTH_LINES = LM_DEPTH_LINES,
  parameter int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                    clock,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [8*LINE_BYTES-1:0] wr_data,
  input  logic [LINE_BYTES-1:0]   wr_mask,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [8*LINE_BYTES-1:0] rd_data
);

  logic [8*LINE_BYTES-1:0] mem [DEPTH_LINES];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < LINE_BYTES; k++) begin
        if (wr_mask[k]) begin
          mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line memory with a masked-write, level-held request port.
// Ports:
//   clock     - single clock, rising edge
//   reset     - asynchronous active-low reset
//   read      - line read request (level-held)
//   write     - line write request (level-held; read wins if both high)
//   address   - line address; only the low log2(DEPTH_LINES) bits index
//   writedata - write line, byte k at [8k+7:8k]
//   writemask - per-byte write enable
//   readdata  - registered read line, held until the next read completes
//   busywait  - stall to requester
// A request accepted in IDLE completes LATENCY edges later, followed by a
// single DONE cycle in which requests are ignored.
module line_memory
  import line_mem_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = LM_LINE_BYTES,
  parameter int unsigned DEPTH_LINES = LM_DEPTH_LINES,
  parameter int unsigned ADDR_W      = LM_ADDR_W,
  parameter int unsigned LATENCY     = LM_LATENCY
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       address,
  input  logic [8*LINE_BYTES-1:0] writedata,
  input  logic [LINE_BYTES-1:0]   writemask,
  output logic [8*LINE_BYTES-1:0] readdata,
  output logic                    busywait
);

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam int unsigned CNT_W = cnt_width(LATENCY);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  op_e                     op_q, op_d;
  logic [8*LINE_BYTES-1:0] wdata_q, wdata_d;
  logic [LINE_BYTES-1:0]   wmask_q, wmask_d;
  logic [8*LINE_BYTES-1:0] readdata_q, readdata_d;

  logic                    ram_we;
  logic [8*LINE_BYTES-1:0] ram_rd_line;

  // Upper address bits alias onto the same lines.
  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[ADDR_W-1:IDX_W];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    readdata_d = readdata_q;
    busywait   = 1'b0;
    ram_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busywait = read | write;
        if (read | write) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          idx_d   = address[IDX_W-1:0];
          op_d    = read ? OP_READ : OP_WRITE;
          wdata_d = writedata;
          wmask_d = writemask;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (op_q == OP_READ) begin
            readdata_d = ram_rd_line;
          end else begin
            ram_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces state to IDLE immediately, so a pending completion can
  // never fire its array write or readdata load while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      op_q       <= OP_READ;
      wdata_q    <= '0;
      wmask_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      readdata_q <= readdata_d;
    end
  end

  line_ram #(
    .LINE_BYTES  (LINE_BYTES),
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_line_ram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_mask (wmask_q),
    .rd_idx  (idx_q),
    .rd_data (ram_rd_line)
  );

  assign readdata = readdata_q;

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: a default-parameter instance (a) and a
// LATENCY=1 / LINE_BYTES=4 / DEPTH_LINES=2 instance (b) share the clock,
// reset and data buses; each has its own request strobes.
module tb_line_memory;

  logic         clock = 1'b0;
  logic         reset;
  logic         rd_a, wr_a, rd_b, wr_b;
  logic [27:0]  address;
  logic [127:0] writedata;
  logic [15:0]  writemask;
  logic [127:0] readdata_a;
  logic [31:0]  readdata_b;
  logic         busy_a, busy_b;

  int unsigned  n_checks = 0;
  int unsigned  n_bad    = 0;

  // Reference state: line contents and the last completed read per instance.
  logic [127:0] mem_a [64];
  logic [127:0] mem_b [2];
  logic [127:0] exp_rd_a, exp_rd_b;

  always #5 clock = ~clock;

  line_memory dut_a (
    .clock     (clock),
    .reset     (reset),
    .read      (rd_a),
    .write     (wr_a),
    .address   (address),
    .writedata (writedata),
    .writemask (writemask),
    .readdata  (readdata_a),
    .busywait  (busy_a)
  );

  line_memory #(
    .LINE_BYTES  (4),
    .DEPTH_LINES (2),
    .ADDR_W      (28),
    .LATENCY     (1)
  ) dut_b (
    .clock     (clock),
    .reset     (reset),
    .read      (rd_b),
    .write     (wr_b),
    .address   (address),
    .writedata (writedata[31:0]),
    .writemask (writemask[3:0]),
    .readdata  (readdata_b),
    .busywait  (busy_b)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] merge_line(input logic [127:0] old, input logic [127:0] data,
                                              input logic [15:0] mask, input int unsigned nb);
    logic [127:0] res = old;
    for (int unsigned b = 0; b < nb; b++) begin
      if (mask[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  task automatic set_req(input bit sel, input logic r, input logic w);
    if (sel) begin rd_b = r; wr_b = w; end
    else     begin rd_a = r; wr_a = w; end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic [127:0] rdata_of(input bit sel);
    return sel ? {96'b0, readdata_b} : readdata_a;
  endfunction

  // Called one time unit after a rising edge with the instance in IDLE;
  // returns one time unit after the edge that leaves DONE.
  task automatic do_op(input bit sel, input bit rd, input bit wr, input logic [27:0] addr,
                       input logic [127:0] data, input logic [15:0] mask,
                       input bit scramble, input bit hold);
    int unsigned lat   = sel ? 1 : 5;
    int unsigned depth = sel ? 2 : 64;
    int unsigned nb    = sel ? 4 : 16;
    int unsigned idx;
    logic [127:0] dmask;
    set_req(sel, rd, wr);
    address   = addr;
    writedata = data;
    writemask = mask;
    @(negedge clock);
    check_eq("busy_idle_req", {127'b0, busy_of(sel)}, 128'd1);
    @(posedge clock);
    idx   = int'(addr % depth);
    dmask = sel ? 128'hFFFF_FFFF : '1;
    if (rd) begin
      if (sel) exp_rd_b = mem_b[idx];
      else     exp_rd_a = mem_a[idx];
    end else if (wr) begin
      if (sel) mem_b[idx] = merge_line(mem_b[idx], data & dmask, mask, nb);
      else     mem_a[idx] = merge_line(mem_a[idx], data, mask, nb);
    end
    for (int unsigned i = 0; i < lat; i++) begin
      #1;
      if (scramble) begin
        set_req(sel, 1'($urandom), 1'($urandom));
        address   = 28'($urandom);
        writedata = rand128();
        writemask = 16'($urandom);
      end
      @(negedge clock);
      check_eq("busy_in_busy", {127'b0, busy_of(sel)}, 128'd1);
      @(posedge clock);
    end
    #1;
    set_req(sel, hold, 1'b0);
    @(negedge clock);
    check_eq("busy_done", {127'b0, busy_of(sel)}, 128'd0);
    check_eq(sel ? "readdata_b" : "readdata_a", rdata_of(sel), sel ? exp_rd_b : exp_rd_a);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [127:0] pat;
    logic [127:0] saved3;
    reset = 1'b0;
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
    address = '0; writedata = '0; writemask = '0;
    exp_rd_a = '0; exp_rd_b = '0;

    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_readdata_a", readdata_a, 128'd0);
    check_eq("rst_readdata_b", {96'b0, readdata_b}, 128'd0);
    check_eq("rst_busy_noreq", {127'b0, busy_a}, 128'd0);
    rd_a = 1'b1;
    #1;
    check_eq("rst_busy_req", {127'b0, busy_a}, 128'd1);
    rd_a = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Give every line a known value before any read.
    for (int unsigned i = 0; i < 64; i++) do_op(0, 0, 1, 28'(i), rand128(), 16'hFFFF, 0, 0);
    for (int unsigned i = 0; i < 2; i++)  do_op(1, 0, 1, 28'(i), rand128(), 16'h000F, 0, 0);

    // Full-mask write then read of line 5.
    pat = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    do_op(0, 0, 1, 28'd5, pat, 16'hFFFF, 0, 0);
    do_op(0, 1, 0, 28'd5, '0, '0, 0, 0);
    check_eq("full_write_line5", readdata_a, pat);

    // Single-byte masked write.
    do_op(0, 0, 1, 28'd5, {16{8'hAA}}, 16'h0001, 0, 0);
    do_op(0, 1, 0, 28'd5, '0, '0, 0, 0);
    check_eq("masked_write_line5", readdata_a, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEAA);

    // Aliased address and read-over-write priority.
    do_op(0, 1, 0, 28'h45, '0, '0, 0, 0);
    check_eq("alias_0x45", readdata_a, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEAA);
    do_op(0, 1, 1, 28'd7, rand128(), 16'hFFFF, 0, 0);
    do_op(0, 1, 0, 28'd7, '0, '0, 1, 0);

    // Reset in the second BUSY cycle of a write to line 3.
    saved3    = mem_a[3];
    address   = 28'd3;
    writedata = ~saved3;
    writemask = 16'hFFFF;
    wr_a      = 1'b1;
    @(negedge clock);
    check_eq("rst_op_busy_req", {127'b0, busy_a}, 128'd1);
    @(posedge clock);
    #1;
    wr_a = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_rd_a = '0;
    exp_rd_b = '0;
    #1;
    check_eq("rst_mid_busy", {127'b0, busy_a}, 128'd0);
    check_eq("rst_mid_readdata", readdata_a, 128'd0);
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_op(0, 1, 0, 28'd3, '0, '0, 0, 0);
    check_eq("rst_line3_kept", readdata_a, saved3);

    // Read held high across several operations with inputs churning in BUSY.
    for (int unsigned i = 0; i < 4; i++) do_op(0, 1, 0, 28'(i * 9 + 1), rand128(), 16'($urandom), 1, 1);
    rd_a = 1'b0;

    // Random traffic on the default instance.
    for (int unsigned i = 0; i < 40; i++) begin
      bit r = 1'($urandom);
      bit w = 1'($urandom);
      if (!r && !w) w = 1'b1;
      do_op(0, r, w, 28'($urandom), rand128(), 16'($urandom), 1'($urandom), 0);
    end

    // Small instance: index wraps on address bit 0.
    do_op(1, 0, 1, 28'd2, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D, 16'h000F, 0, 0);
    do_op(1, 1, 0, 28'd0, '0, '0, 0, 0);
    check_eq("wrap_b_idx0", {96'b0, readdata_b}, 128'hCAFE_F00D);
    do_op(1, 0, 1, 28'd7, 128'h1234_5678, 16'h0005, 0, 0);
    do_op(1, 1, 0, 28'd1, '0, '0, 0, 0);
    for (int unsigned i = 0; i < 20; i++) begin
      bit r = 1'($urandom);
      bit w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      do_op(1, r, w, 28'($urandom), rand128(), 16'($urandom), 1'($urandom), 0);
    end
    for (int unsigned i = 0; i < 3; i++) do_op(1, 1, 0, 28'(i), '0, '0, 0, 1);
    rd_b = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
